fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch FSM with IF/ID register, skid buffer and branch redirect.
// Ports: clk/reset (sync, active-high); stall from decode; branchTaken/branchPc/branchImmediate redirect;
//   imemReq/imemAddr/imemReady/imemData instruction memory handshake;
//   instructionOut/pcOut/validOut IF/ID entry; misalignErr sticky misaligned-target flag.
// Optional macro FETCH_PERF_EN adds fetchCount/stallCycles performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int unsigned PC_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchPc,
  input  logic [31:0] branchImmediate,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instructionOut,
  output logic [31:0] pcOut,
  output logic        validOut,
  output logic        misalignErr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCycles
`endif
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;
  state_t state;
  logic [31:0] pc, skid_instr, skid_pc, target, aligned, next_pc;
  logic hs, outstanding;
  always_comb begin
    target = branchPc + branchImmediate;
    aligned = {target[31:2], 2'b00};
    next_pc = pc + 32'(PC_STEP);
    hs = imemReq & imemReady;
    outstanding = imemReq & ~imemReady;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      imemReq <= 1'b0;
      imemAddr <= RESET_PC;
      instructionOut <= 32'h00000013;
      pcOut <= 32'h0;
      validOut <= 1'b0;
      misalignErr <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc <= 32'h0;
    end else if (branchTaken) begin
      // An outstanding request must still complete; its word is dropped in DRAIN.
      pc <= aligned;
      validOut <= 1'b0;
      misalignErr <= misalignErr | (|target[1:0]);
      imemReq <= 1'b1;
      state <= outstanding ? DRAIN : FETCH;
      if (!outstanding) imemAddr <= aligned;
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (hs) begin
            pc <= next_pc;
            if (stall) begin
              skid_instr <= imemData;
              skid_pc <= pc;
              imemReq <= 1'b0;
              state <= HOLD;
            end else begin
              instructionOut <= imemData;
              pcOut <= pc;
              validOut <= 1'b1;
              imemAddr <= next_pc;
              state <= FETCH;
            end
          end else begin
            // Request is raised one cycle after reset; only a raised request can be waiting.
            if (!stall) validOut <= 1'b0;
            if (imemReq) state <= WAIT;
            imemReq <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            instructionOut <= skid_instr;
            pcOut <= skid_pc;
            validOut <= 1'b1;
            imemReq <= 1'b1;
            imemAddr <= pc;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (imemReady) begin
            imemAddr <= pc;
            state <= FETCH;
          end
        end
      endcase
    end
  end
`ifdef FETCH_PERF_EN
  logic load, waiting;
  always_comb begin
    load = ~branchTaken & ~stall & (state == HOLD ? 1'b1 : hs);
    waiting = ~branchTaken & outstanding & (state != DRAIN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchCount <= 32'h0;
      stallCycles <= 32'h0;
    end else begin
      fetchCount <= fetchCount + 32'(load);
      stallCycles <= stallCycles + 32'(waiting);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against a program-order stream model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall, branchTaken, imemReq, imemReady, validOut, misalignErr;
  logic [31:0] branchPc, branchImmediate, imemAddr, imemData, instructionOut, pcOut;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCount, stallCycles;
`endif
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken),
    .branchPc(branchPc), .branchImmediate(branchImmediate),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemData(imemData),
    .instructionOut(instructionOut), .pcOut(pcOut), .validOut(validOut),
    .misalignErr(misalignErr)
`ifdef FETCH_PERF_EN
    , .fetchCount(fetchCount), .stallCycles(stallCycles)
`endif
  );
  int errors = 0;
  int checks = 0;
  int idle = 0;
  int w = 0;
  int minw = 0;
  int maxw = 0;
  logic [63:0] exp_q[$];
  logic [31:0] np = 32'h0;
  logic mis = 1'b0;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 32'h20 ? 32'h00552023 : (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // One clock of stimulus, then the model applies what that edge means for program order.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bp, input logic [31:0] bi);
    logic [31:0] t;
    reset = r;
    stall = s;
    branchTaken = b;
    branchPc = bp;
    branchImmediate = bi;
    if (!r && imemReq && w == 0) begin
      imemReady = 1'b1;
      imemData = memf(imemAddr);
      w = $urandom_range(maxw, minw);
    end else begin
      imemReady = 1'b0;
      imemData = $urandom;
      if (!r && imemReq) w--;
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      np = 32'h0;
      mis = 1'b0;
      w = 0;
    end else if (b) begin
      t = bp + bi;
      exp_q.delete();
      np = {t[31:2], 2'b00};
      if (t[1:0] != 2'b00) mis = 1'b1;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back({memf(np), np});
      np += 32'd4;
    end
  endtask
  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic run(input int n, input int sp, input int bp, input int rp);
    logic s, b, r;
    logic [31:0] pcv, imm;
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(999) < rp);
      s = ($urandom_range(99) < sp);
      b = ($urandom_range(99) < bp);
      pcv = $urandom & 32'hFFFFFFFC;
      imm = $urandom & 32'hFFFFFFFE;
      step(r, s, b, pcv, imm);
    end
  endtask
  // Monitor: decode accepts the IF/ID entry on an edge where it is valid and not stalled.
  logic [63:0] e;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("misalign", {31'h0, misalignErr}, {31'h0, mis});
      if (validOut && !stall) begin
        idle = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %h expected no output", pcOut);
        end else begin
          e = exp_q.pop_front();
          chk("pcOut", pcOut, e[31:0]);
          chk("instructionOut", instructionOut, e[63:32]);
        end
      end else begin
        idle++;
        if (idle > 200) begin
          checks++;
          errors++;
          $display("FAIL progress: got %0d idle cycles expected at most 200", idle);
          idle = 0;
        end
      end
    end else idle = 0;
  end
  initial begin
    int k;
    stall = 1'b0;
    branchTaken = 1'b0;
    branchPc = 32'h0;
    branchImmediate = 32'h0;
    imemReady = 1'b0;
    imemData = 32'h0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_req", {31'h0, imemReq}, 32'h0);
    chk("rst_addr", imemAddr, 32'h0);
    chk("rst_instr", instructionOut, 32'h00000013);
    chk("rst_pc", pcOut, 32'h0);
    chk("rst_valid", {31'h0, validOut}, 32'h0);
    chk("rst_mis", {31'h0, misalignErr}, 32'h0);
    // zero-wait memory
    idle_steps(1);
    chk("first_valid_low", {31'h0, validOut}, 32'h0);
    chk("first_req", {31'h0, imemReq}, 32'h1);
    idle_steps(1);
    chk("first_valid_high", {31'h0, validOut}, 32'h1);
    chk("first_pc", pcOut, 32'h0);
    idle_steps(6);
    // two wait states at pc 0x10
    minw = 2;
    maxw = 2;
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h10);
    chk("wait_addr0", imemAddr, 32'h10);
    idle_steps(1);
    chk("wait_addr1", imemAddr, 32'h10);
    idle_steps(1);
    chk("wait_addr2", imemAddr, 32'h10);
    idle_steps(1);
    chk("wait_addr_next", imemAddr, 32'h14);
    idle_steps(6);
    // stall while the word at 0x20 returns
    minw = 0;
    maxw = 0;
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h20);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle_steps(6);
    // redirect with a request outstanding
    minw = 3;
    maxw = 3;
    k = 0;
    while (!(imemReq && w > 0) && k < 10) begin
      idle_steps(1);
      k++;
    end
    step(1'b0, 1'b0, 1'b1, 32'h40, 32'hFFFFFFF0);
    chk("drain_mis", {31'h0, misalignErr}, 32'h0);
    idle_steps(16);
    // misaligned target
    minw = 0;
    maxw = 0;
    idle_steps(5);
    step(1'b0, 1'b0, 1'b1, 32'h100, 32'h2);
    chk("mis_set", {31'h0, misalignErr}, 32'h1);
    chk("mis_addr", imemAddr, 32'h100);
    idle_steps(6);
    // pc wrap-around
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h8);
    idle_steps(10);
    chk("mis_sticky", {31'h0, misalignErr}, 32'h1);
    // reset mid-transaction
    minw = 2;
    maxw = 2;
    idle_steps(2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst2_mis", {31'h0, misalignErr}, 32'h0);
    chk("rst2_valid", {31'h0, validOut}, 32'h0);
    chk("rst2_req", {31'h0, imemReq}, 32'h0);
    chk("rst2_addr", imemAddr, 32'h0);
    // random traffic
    minw = 0;
    maxw = 3;
    run(3000, 30, 5, 3);
    run(1000, 10, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
